serial_rx_framer: RTL and testbench

SERIAL_RX_FRAMER -- requirements
Module: serial_rx_framer

---
 rtl/serial_rx_framer.sv | 248 ++++++++++++++++++++++++
 tb/tb_serial_rx_framer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_framer.sv
// rtl/serial_rx_framer.sv - Oversampling serial receiver/framer with a single holding register
//
// Receives LSB-first asynchronous frames (start bit, DATA_BITS data bits,
// optional parity bit, one stop bit) on rx. The line is oversampled at
// CLK_DIV clocks per bit, and each bit is sampled near its middle. A good
// frame is placed in one holding register and offered to the consumer
// through a valid/ready handshake. A bad frame, or a good frame that finds
// the holding register still full, produces a one-cycle status pulse.
//
// Optional feature macro: SERIAL_RX_PARITY_EN
//   defined   - a parity bit follows the data bits and is checked
//               (PARITY_ODD=1 selects odd parity, 0 selects even parity)
//   undefined - there is no parity bit and parity_err is tied low
//
// Parameters:
//   CLK_DIV     clk cycles per bit; must be even and >= 4
//   DATA_BITS   data bits per frame (1..16)
//   PARITY_ODD  parity sense; used only with SERIAL_RX_PARITY_EN
//
// Ports:
//   clk         single clock; all logic runs on posedge
//   rst         synchronous active-high reset
//   rx          asynchronous serial line, idle high
//   data_out    last accepted frame; stable while data_valid is high
//   data_valid  data_out holds an unconsumed frame
//   data_ready  consumer takes data_out when data_valid is also high
//   frame_err   one-cycle pulse: stop bit sampled low
//   parity_err  one-cycle pulse: received parity bit does not match the data
//   overrun     one-cycle pulse: good frame dropped because the holding register is full
//   busy        high whenever the receiver is not idle

module serial_rx_framer #(
    parameter int CLK_DIV    = 96,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (CLK_DIV < 4 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
        $error("serial_rx_framer: CLK_DIV must be even and >= 4");
    end

    if (DATA_BITS < 1 || DATA_BITS > 16) begin : g_bad_data_bits
        $error("serial_rx_framer: DATA_BITS must be in 1..16");
    end

    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("serial_rx_framer: PARITY_ODD must be 0 or 1");
    end

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(DATA_BITS + 1);

    // Counter values at which a bit is sampled: half a bit after the start
    // edge, then one full bit period for each later bit.
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shift_next;

    // Set for one cycle after the stop bit has been sampled; the frame is
    // judged and delivered on that following cycle.
    logic                 frame_done;
    logic                 stop_bit;
    logic                 par_bad;

    // Frames arrive LSB first, so each new bit enters at the MSB and the
    // earlier bits move down; after DATA_BITS samples bit 0 sits at the LSB.
    always_comb begin
        shift_next                = shreg >> 1;
        shift_next[DATA_BITS-1]   = rx_s;
    end

`ifdef SERIAL_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    logic par_bit;

    // shreg is untouched between the last data sample and the judgement
    // cycle, so it still holds the complete received word here.
    assign par_bad = par_bit != ((^shreg) ^ PAR_ODD);
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            frame_done <= 1'b0;
            stop_bit   <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            // Two-flop synchronizer; only rx_s is used past this point.
            rx_meta <= rx;
            rx_s    <= rx_meta;

            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= 1'b0;
`endif

            // ---------------- holding register / handshake ----------------
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            // A frame landing on the same cycle as an accept overrides the
            // clear above, so data_valid stays high with the new word.
            if (frame_done) begin
                if (!stop_bit) begin
                    frame_err <= 1'b1;
                end else if (par_bad) begin
`ifdef SERIAL_RX_PARITY_EN
                    parity_err <= 1'b1;
`endif
                end else if (data_valid && !data_ready) begin
                    overrun <= 1'b1;
                end else begin
                    data_out   <= shreg;
                    data_valid <= 1'b1;
                end
            end

            // ---------------- bit-level receive FSM ----------------
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        if (rx_s) begin
                            // Line returned high before mid-bit: a glitch, not a start bit.
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        shreg <= shift_next;
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef SERIAL_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt        <= '0;
                        stop_bit   <= rx_s;
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_framer.sv
// tb/tb_serial_rx_framer.sv - Self-checking bench for serial_rx_framer

module tb_serial_rx_framer;

    localparam int CLK_DIV    = 16;
    localparam int DATA_BITS  = 8;
    localparam int PARITY_ODD = 0;

    // Edges from the first edge that sees rx low to the edge that raises data_valid.
`ifdef SERIAL_RX_PARITY_EN
    localparam int LAT     = 2 + CLK_DIV / 2 + (DATA_BITS + 2) * CLK_DIV + 1;
    localparam int LAT_LIT = 171;
`else
    localparam int LAT     = 2 + CLK_DIV / 2 + (DATA_BITS + 1) * CLK_DIV + 1;
    localparam int LAT_LIT = 155;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    serial_rx_framer #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (DATA_BITS),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model: each sent frame schedules one outcome at the edge
    // given by the latency rule; the outcome is resolved against the model's
    // holding register and data_ready at that edge.
    // ------------------------------------------------------------------
    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       stop_ok;
        logic       pbit;
    } ev_t;

    ev_t        evq[$];
    ev_t        ev;
    int         cyc      = 0;
    logic       m_valid  = 1'b0;
    logic [7:0] m_data   = 8'h00;
    logic       m_fe     = 1'b0;
    logic       m_ov     = 1'b0;
    logic       m_pe     = 1'b0;
    logic       was_valid;
    logic       par_ok;

    always @(posedge clk) begin
        cyc++;
        m_fe = 1'b0;
        m_ov = 1'b0;
        m_pe = 1'b0;
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 8'h00;
            evq.delete();
        end else begin
            was_valid = m_valid;
            if (m_valid && data_ready) m_valid = 1'b0;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
`ifdef SERIAL_RX_PARITY_EN
                par_ok = (ev.pbit == ((^ev.d) ^ (PARITY_ODD != 0)));
`else
                par_ok = 1'b1;
`endif
                if (!ev.stop_ok)                  m_fe = 1'b1;
                else if (!par_ok)                 m_pe = 1'b1;
                else if (was_valid && !data_ready) m_ov = 1'b1;
                else begin
                    m_data  = ev.d;
                    m_valid = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare plus pulse/rise bookkeeping for directed checks
    // ------------------------------------------------------------------
    logic chk_en    = 1'b0;
    logic dv_prev   = 1'b0;
    int   fe_cnt    = 0;
    int   ov_cnt    = 0;
    int   pe_cnt    = 0;
    int   dv_rises  = 0;
    int   last_rise = 0;
    int   last_t0   = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("data_valid", data_valid, m_valid);
            chk("data_out",   data_out,   m_data);
            chk("frame_err",  frame_err,  m_fe);
            chk("overrun",    overrun,    m_ov);
            chk("parity_err", parity_err, m_pe);
            if (frame_err === 1'b1)  fe_cnt++;
            if (overrun === 1'b1)    ov_cnt++;
            if (parity_err === 1'b1) pe_cnt++;
            if (data_valid === 1'b1 && dv_prev !== 1'b1) begin
                dv_rises++;
                last_rise = cyc;
            end
            dv_prev = data_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbit);
        ev_t e;
        @(negedge clk);
        last_t0   = cyc;
        e.cyc     = cyc + 1 + LAT;
        e.d       = d;
        e.stop_ok = stop;
        e.pbit    = pbit;
        evq.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        drive_bit(pbit);
`endif
        drive_bit(stop);
        rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    int fe0, ov0, pe0, dv0, bc;

    initial begin
        rx         = 1'b1;
        rst        = 1'b1;
        data_ready = 1'b1;
        idle(3);

        // Reset state
        chk("rst_data_out",   data_out,   0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_frame_err",  frame_err,  0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_overrun",    overrun,    0);
        chk("rst_busy",       busy,       0);
        chk_en = 1'b1;
        rst    = 1'b0;
        idle(5);

        // Good frame 0xA5 and its exact latency
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        chk("a5_latency", last_rise - (last_t0 + 1), LAT_LIT);
        chk("a5_data",    data_out, 8'hA5);
        chk("a5_rises",   dv_rises, 1);
        chk("a5_errors",  fe_cnt + ov_cnt + pe_cnt, 0);

        // Short low glitch on rx
        dv0 = dv_rises;
        fe0 = fe_cnt;
        bc  = 0;
        @(negedge clk);
        rx = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
            if (i == 3) rx = 1'b1;
        end
        chk("glitch_busy_cycles", bc, 8);
        chk("glitch_busy_end",    busy, 0);
        chk("glitch_no_valid",    dv_rises - dv0, 0);
        chk("glitch_no_ferr",     fe_cnt - fe0, 0);

        // Stop bit low: frame error, holding register untouched
        fe0 = fe_cnt;
        dv0 = dv_rises;
        send_frame(8'h5A, 1'b0, 1'b0);
        idle(40);
        chk("ferr_pulses",   fe_cnt - fe0, 1);
        chk("ferr_no_valid", dv_rises - dv0, 0);
        chk("ferr_data",     data_out, 8'hA5);

        // Overrun: consumer stalled across two frames
        data_ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        idle(10);
        chk("ovr_first_valid", data_valid, 1);
        chk("ovr_first_data",  data_out, 8'h11);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(10);
        chk("ovr_pulses", ov_cnt - ov0, 1);
        chk("ovr_held",   data_out, 8'h11);
        data_ready = 1'b1;
        idle(2);
        chk("ovr_drained", data_valid, 0);

        // New frame lands on the same edge as an accept
        data_ready = 1'b0;
        send_frame(8'h33, 1'b1, 1'b0);
        idle(10);
        ov0 = ov_cnt;
        fork
            send_frame(8'h44, 1'b1, 1'b0);
            begin
                @(negedge clk);
                #1;
                for (int i = 0; i < 400 && cyc < last_t0 + LAT; i++) @(negedge clk);
                data_ready = 1'b1;
            end
        join
        idle(10);
        chk("same_cycle_data",    data_out, 8'h44);
        chk("same_cycle_no_ovr",  ov_cnt - ov0, 0);
        chk("same_cycle_drained", data_valid, 0);

        // Reset during data bit 3, then a clean frame
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        pe0 = pe_cnt;
        dv0 = dv_rises;
        @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b1;
        repeat (CLK_DIV / 2) @(negedge clk);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        idle(40);
        chk("rst_mid_idle",   busy, 0);
        chk("rst_mid_pulses", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0), 0);
        chk("rst_mid_valid",  dv_rises - dv0, 0);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(20);
        chk("after_rst_data",    data_out, 8'h3C);
        chk("after_rst_latency", last_rise - (last_t0 + 1), LAT_LIT);

`ifdef SERIAL_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the correct parity bit is 1
        pe0 = pe_cnt;
        dv0 = dv_rises;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
        chk("par_bad_pulse", pe_cnt - pe0, 1);
        chk("par_bad_valid", dv_rises - dv0, 0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        chk("par_good_data",  data_out, 8'h07);
        chk("par_good_rises", dv_rises - dv0, 1);
`endif

        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
